// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for the 16-bit simple processor: IR capture and bus/load sequencing.
// Optional build macro PROC_MVNZ_EN enables opcode 110 (mvnz, conditional move on nz).
module proc_control_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic              nz,
    output logic [8:0]        ir,
    output logic [7:0]        r_out,
    output logic              din_out,
    output logic              g_out,
    output logic [7:0]        r_in,
    output logic              a_in,
    output logic              g_in,
    output logic              addsub,
    output logic              done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b110;
`endif

    state_t     state;
    logic       ir_load;
    logic [2:0] op;
    logic [7:0] sel_x;
    logic [7:0] sel_y;

    assign ir_load = run & (state == T0);
    assign op      = ir[8:6];
    assign sel_x   = 8'd1 << ir[5:3];
    assign sel_y   = 8'd1 << ir[2:0];

`ifndef PROC_MVNZ_EN
    logic unused_nz;
    assign unused_nz = nz;
`endif
    // Only the top nine bits of din form the instruction; the rest is immediate data.
    logic unused_din;
    assign unused_din = ^din;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            ir    <= 9'b0;
        end else begin
            case (state)
                T0: begin
                    if (ir_load) begin
                        ir    <= din[DATA_W-1 -: 9];
                        state <= T1;
                    end
                end
                T1: begin
                    if (op == OP_ADD || op == OP_SUB) state <= T2;
                    else                              state <= T0;
                end
                T2:      state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Moore decode from state and the held IR; nz only matters for mvnz in T1.
    always_comb begin
        r_out   = 8'b0;
        din_out = 1'b0;
        g_out   = 1'b0;
        r_in    = 8'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        case (state)
            T1: begin
                case (op)
                    OP_MV: begin
                        r_out = sel_y;
                        r_in  = sel_x;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = sel_x;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out = sel_x;
                        a_in  = 1'b1;
                    end
`ifdef PROC_MVNZ_EN
                    OP_MVNZ: begin
                        if (nz) begin
                            r_out = sel_y;
                            r_in  = sel_x;
                        end
                        done = 1'b1;
                    end
`endif
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                r_out  = sel_y;
                g_in   = 1'b1;
                addsub = (op == OP_SUB);
            end
            T3: begin
                g_out = 1'b1;
                r_in  = sel_x;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Multi-cycle control FSM for the 16-bit simple processor datapath.
- Captures the instruction word from din into an internal IR.
- Sequences the bus-source selects (r0..r7, din, g), register load enables, A/G loads and the ALU add/sub select.
- Drives the one-hot source-select inputs of the register bus mux, so at most one source is ever enabled per cycle.

Parameters:
- DATA_W, 16, width of din. Must be >= 9; IR taken from din[DATA_W-1 -: 9].

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  start request; sampled only in state T0
- din  in  DATA_W  instruction word (T0), immediate for mvi (T1)
- nz  in  1  G-register-not-zero flag from datapath (used only with MVNZ_EN)
- ir  out  9  current instruction register {III,XXX,YYY}
- r_out  out  8  one-hot bus select, bit i = ri_out
- din_out  out  1  din drives bus
- g_out  out  1  G drives bus
- r_in  out  8  register load enables, bit i = ri_in
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- addsub  out  1  0 = add, 1 = sub
- done  out  1  instruction completes this cycle

Behaviour:
- Clock and reset: one clock (clock); reset asynchronous, active-high.
- Reset: state=T0, ir=9'b0.
  - Every output except ir_in-related logic is 0 during and after reset until run.
- Output timing:
  - Outputs are Moore-decoded from state and the registered ir.
  - Exception: the internal IR load is run & (state==T0).
- IR fields: III=ir[8:6] opcode, XXX=ir[5:3] destination, YYY=ir[2:0] source.
- Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-din; 010 add Rx<-Rx+Ry; 011 sub Rx<-Rx-Ry; 110 mvnz (optional); others undefined.
- T0:
  - If run: ir <= din[DATA_W-1 -: 9], go to T1.
  - Otherwise stay in T0. No bus source is enabled.
- T1:
  - mv: r_out[Y]=1, r_in[X]=1, done=1, go to T0.
  - mvi: din_out=1, r_in[X]=1, done=1, go to T0.
  - add/sub: r_out[X]=1, a_in=1, go to T2.
  - Undefined opcode: done=1, no enables, go to T0.
- T2: r_out[Y]=1, g_in=1, addsub=(III==011), go to T3.
- T3: g_out=1, r_in[X]=1, done=1, go to T0.
- Latency:
  - mv/mvi: 2 cycles from run sample to done.
  - add/sub: 4 cycles from run sample to done.
- Invariants:
  - At most one of r_out[7:0], din_out, g_out is high in any cycle.
  - At most one r_in bit is high in any cycle.
  - addsub=0 outside T2.
- run during T1..T3: ignored. run held high continuously: the next instruction is captured in the T0 that follows done.
- X==Y: legal. mv Rx,Rx asserts r_out[X] and r_in[X] together; add Rx,Rx doubles Rx.
- Reset asserted mid-instruction: the FSM returns to T0 immediately (asynchronously), and no partial register write occurs after the reset edge.
- ir changes only in T0 on run; it is stable for the full instruction.

Optional Feature:
- Macro: PROC_MVNZ_EN.
- Defined: opcode 110 is mvnz.
  - In T1: if nz=1, r_out[Y]=1 and r_in[X]=1; if nz=0, no enables.
  - In both cases done=1, then go to T0.
  - nz is sampled in T1 only.
- Undefined: 110 is treated as undefined (done in T1, no enables) and the nz input is ignored.

Test Plan:
- Reset release, run=0 for 5 cycles -> state T0, ir=0, all select/enable/done outputs 0 every cycle.
- din[15:7]=000_011_101 (mv R3,R5), run pulse -> next cycle r_out=8'b0010_0000, r_in=8'b0000_1000, done=1; following cycle all 0.
- din[15:7]=001_010_000 then din=16'h00A5 (mvi R2,#A5) -> T1: din_out=1, r_in=8'b0000_0100, done=1.
- din[15:7]=011_001_110 (sub R1,R6) -> T1: r_out[1],a_in; T2: r_out[6],g_in,addsub=1; T3: g_out,r_in[1],done; exactly 4 cycles total; one-hot bus check every cycle.
- Assert reset during T2 of add R0,R7 -> state T0, outputs 0 next sample, no r_in pulse; then run mv R4,R0 completes normally.
- With PROC_MVNZ_EN, opcode 110_000_001: nz=1 -> r_out[1], r_in[0], done; nz=0 -> done only. Without the macro: done only regardless of nz.
